// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen -- serial bit-sequence transmitter
//
// Loads a pattern of up to PAT_W bits and shifts it out MSB-first on x. Each
// bit is held for BIT_CYCLES clocks. The pattern is sent repeat_n+1 times, with
// gap idle bit-periods between repetitions. This is the driving end of the
// serial-detector interface and doubles as an on-chip pattern injector.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset (0 = reset asserted)
//   start     in   transfer request, sampled only while idle
//   abort     in   synchronous abort of the transfer in progress
//   pattern   in   [PAT_W] bit pat_len-1 is sent first, bit 0 last
//   pat_len   in   [LEN_W] number of pattern bits, 1..PAT_W (larger clamps)
//   repeat_n  in   [CNT_W] extra repetitions; total sends = repeat_n+1
//   gap       in   [CNT_W] idle bit-periods between repetitions
//   x         out  serial data (registered)
//   x_valid   out  high while x carries a pattern bit (registered)
//   busy      out  high from start acceptance until completion (registered)
//   done      out  one-clock pulse on normal completion (registered)
// -----------------------------------------------------------------------------
module seq_gen #(
   parameter int   PAT_W      = 8,
   parameter int   LEN_W      = 4,
   parameter int   CNT_W      = 8,
   parameter int   BIT_CYCLES = 3,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] pat_len,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic [CNT_W-1:0] gap,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   // Bit-period counter width; keep at least one bit when BIT_CYCLES == 1.
   localparam int               CYC_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_GAP
   } state_t;

   state_t           state;
   logic [PAT_W-1:0] pat_al_q;    // latched pattern, first bit moved to the MSB
   logic [PAT_W-1:0] shift_q;     // working copy, MSB is the bit now on x
   logic [LEN_W-1:0] len_q;       // effective (clamped) length
   logic [LEN_W-1:0] bits_left_q; // bits still to send after the current one
   logic [CNT_W-1:0] rep_left_q;  // repetitions still to send after this one
   logic [CNT_W-1:0] gap_q;       // latched gap length in bit-periods
   logic [CNT_W-1:0] gap_left_q;  // gap bit-periods remaining, including current
   logic [CYC_W-1:0] cyc_q;       // clock index within the current bit-period

   logic [LEN_W-1:0] eff_len;
   logic [PAT_W-1:0] aligned;
   logic [PAT_W-1:0] shift_nxt;
   logic             start_ok;
   logic             period_end;

   // NOTE: every signal driven here gets a value on every path (defaults or a
   // full if/else); leaving any path unassigned would infer a latch.
   always_comb begin
      eff_len    = (pat_len > LEN_MAX) ? LEN_MAX : pat_len;
      // Left-justify so the first bit to send always sits at PAT_W-1 and the
      // shifter never needs a variable index.
      aligned    = pattern << (LEN_MAX - eff_len);
      shift_nxt  = shift_q << 1;
      start_ok   = start && !abort && (pat_len != '0);
      period_end = (cyc_q == CYC_LAST);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         pat_al_q    <= '0;
         shift_q     <= '0;
         len_q       <= '0;
         bits_left_q <= '0;
         rep_left_q  <= '0;
         gap_q       <= '0;
         gap_left_q  <= '0;
         cyc_q       <= '0;
         x           <= IDLE_LEVEL;
         x_valid     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  state       <= S_SEND;
                  pat_al_q    <= aligned;
                  shift_q     <= aligned;
                  len_q       <= eff_len;
                  bits_left_q <= eff_len - 1'b1;
                  rep_left_q  <= repeat_n;
                  gap_q       <= gap;
                  cyc_q       <= '0;
                  x           <= aligned[PAT_W-1];
                  x_valid     <= 1'b1;
                  busy        <= 1'b1;
               end
            end

            S_SEND: begin
               if (abort) begin
                  state   <= S_IDLE;
                  x       <= IDLE_LEVEL;
                  x_valid <= 1'b0;
                  busy    <= 1'b0;
               end else if (!period_end) begin
                  cyc_q <= cyc_q + 1'b1;
               end else begin
                  cyc_q <= '0;
                  if (bits_left_q != '0) begin
                     // Next lower pattern bit.
                     bits_left_q <= bits_left_q - 1'b1;
                     shift_q     <= shift_nxt;
                     x           <= shift_nxt[PAT_W-1];
                  end else if (rep_left_q != '0) begin
                     rep_left_q <= rep_left_q - 1'b1;
                     if (gap_q != '0) begin
                        state      <= S_GAP;
                        gap_left_q <= gap_q;
                        x          <= IDLE_LEVEL;
                        x_valid    <= 1'b0;
                     end else begin
                        // Zero gap: restart the pattern with no idle cycle.
                        shift_q     <= pat_al_q;
                        bits_left_q <= len_q - 1'b1;
                        x           <= pat_al_q[PAT_W-1];
                     end
                  end else begin
                     // Last bit of the last repetition.
                     state   <= S_IDLE;
                     x       <= IDLE_LEVEL;
                     x_valid <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end

            S_GAP: begin
               if (abort) begin
                  state   <= S_IDLE;
                  x       <= IDLE_LEVEL;
                  x_valid <= 1'b0;
                  busy    <= 1'b0;
               end else if (!period_end) begin
                  cyc_q <= cyc_q + 1'b1;
               end else begin
                  cyc_q <= '0;
                  if (gap_left_q == CNT_W'(1)) begin
                     state       <= S_SEND;
                     shift_q     <= pat_al_q;
                     bits_left_q <= len_q - 1'b1;
                     x           <= pat_al_q[PAT_W-1];
                     x_valid     <= 1'b1;
                  end else begin
                     gap_left_q <= gap_left_q - 1'b1;
                  end
               end
            end

            default: begin
               state   <= S_IDLE;
               x       <= IDLE_LEVEL;
               x_valid <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_gen -- self-checking bench for seq_gen.
// Each transfer is expanded into the expected per-clock trace of
// {x, x_valid, busy, done} directly from the transfer rules; the DUT outputs are
// compared against that trace one clock at a time, 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_seq_gen;

   localparam int   PAT_W = 8;
   localparam int   LEN_W = 4;
   localparam int   CNT_W = 8;
   localparam int   BC    = 3;
   localparam logic IDLE  = 1'b0;
   localparam logic [3:0] IDLE_VEC = {IDLE, 3'b000};

   logic             clk;
   logic             reset;
   logic             start;
   logic             abort;
   logic [PAT_W-1:0] pattern;
   logic [LEN_W-1:0] pat_len;
   logic [CNT_W-1:0] repeat_n;
   logic [CNT_W-1:0] gap;
   logic             x;
   logic             x_valid;
   logic             busy;
   logic             done;

   seq_gen #(
      .PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W),
      .BIT_CYCLES(BC), .IDLE_LEVEL(IDLE)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .pattern(pattern), .pat_len(pat_len), .repeat_n(repeat_n), .gap(gap),
      .x(x), .x_valid(x_valid), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [3:0] exp_q[$];

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got {x,xv,busy,done}=%b want=%b at t=%0t", tag, got, want, $time);
      end
   endtask

   function automatic logic [3:0] obs();
      return {x, x_valid, busy, done};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected trace from the accepting edge onwards: one entry per clock,
   // ending with the done cycle.
   task automatic build(input logic [7:0] pat, input int len, input int rep, input int gp);
      int eff;
      exp_q.delete();
      eff = (len > PAT_W) ? PAT_W : len;
      for (int r = 0; r <= rep; r++) begin
         for (int b = eff - 1; b >= 0; b--)
            repeat (BC) exp_q.push_back({pat[b], 3'b110});
         if (r < rep)
            repeat (gp * BC) exp_q.push_back({IDLE, 3'b010});
      end
      exp_q.push_back({IDLE, 3'b001});
   endtask

   task automatic launch(input logic [7:0] pat, input int len, input int rep, input int gp);
      pattern  = pat;
      pat_len  = LEN_W'(len);
      repeat_n = CNT_W'(rep);
      gap      = CNT_W'(gp);
      abort    = 1'b0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      build(pat, len, rep, gp);
   endtask

   // Full transfer; inputs are scrambled and start is toggled while busy to
   // show they do not disturb the transfer. Returns in the done cycle.
   task automatic xfer(input logic [7:0] pat, input int len, input int rep, input int gp,
                       input string tag);
      launch(pat, len, rep, gp);
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("%s[%0d]", tag, i), obs(), exp_q[i]);
         if (i != exp_q.size() - 1) begin
            start    = 1'($urandom_range(0, 1));
            pattern  = PAT_W'($urandom);
            pat_len  = LEN_W'($urandom);
            repeat_n = CNT_W'($urandom);
            gap      = CNT_W'($urandom);
            tick();
         end
      end
      start = 1'b0;
   endtask

   // Transfer aborted once the k-th trace entry has been checked.
   task automatic xfer_abort(input logic [7:0] pat, input int len, input int rep, input int gp,
                             input int k, input string tag);
      launch(pat, len, rep, gp);
      for (int i = 0; i <= k; i++) begin
         check($sformatf("%s[%0d]", tag, i), obs(), exp_q[i]);
         if (i != k) tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check({tag, "_after"}, obs(), IDLE_VEC);
   endtask

   task automatic idle_chk(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         check($sformatf("%s[%0d]", tag, i), obs(), IDLE_VEC);
      end
   endtask

   initial begin
      start    = 1'b0;
      abort    = 1'b0;
      pattern  = '0;
      pat_len  = '0;
      repeat_n = '0;
      gap      = '0;
      reset    = 1'b1;
      #2 reset = 1'b0;
      #1 check("reset_async", obs(), IDLE_VEC);
      #20 check("reset_held", obs(), IDLE_VEC);
      @(negedge clk) reset = 1'b1;
      idle_chk(3, "post_reset");

      // Directed cases, back-to-back (each start lands in the previous done cycle).
      xfer(8'h0B, 4, 0, 0, "single");
      xfer(8'h05, 3, 1, 2, "rep_gap");
      xfer(8'h02, 2, 2, 0, "b2b_nogap");
      idle_chk(2, "idle_a");

      // pat_len = 0 is ignored.
      pattern = 8'hFF; pat_len = '0; start = 1'b1;
      idle_chk(3, "len0");
      start = 1'b0;

      // abort wins over start in IDLE.
      pat_len = 4'd4; start = 1'b1; abort = 1'b1;
      idle_chk(2, "abort_start_idle");
      start = 1'b0; abort = 1'b0;

      // abort at the 5th clock of a transfer, then during a gap.
      xfer_abort(8'hA5, 8, 0, 0, 4, "abort_send");
      idle_chk(4, "no_done_a");
      xfer_abort(8'h01, 1, 1, 3, 5, "abort_gap");
      idle_chk(4, "no_done_b");

      // Asynchronous reset between edges in the middle of SEND.
      launch(8'hC3, 8, 1, 0);
      for (int i = 0; i < 7; i++) begin
         check($sformatf("rst_mid[%0d]", i), obs(), exp_q[i]);
         tick();
      end
      #3 reset = 1'b0;
      #1 check("rst_immediate", obs(), IDLE_VEC);
      @(negedge clk) check("rst_hold", obs(), IDLE_VEC);
      @(negedge clk) reset = 1'b1;
      idle_chk(5, "rst_release");

      // Clamp and maximum counts.
      xfer(8'b1011_0010, 15, 0, 0, "clamp");
      xfer(PAT_W'($urandom), 8, 255, 0, "max_rep");
      xfer(PAT_W'($urandom), 1, 2, 255, "max_gap");
      idle_chk(1, "idle_b");

      // Randomized transfers.
      for (int t = 0; t < 25; t++) begin
         xfer(PAT_W'($urandom), $urandom_range(1, 15), $urandom_range(0, 3),
              $urandom_range(0, 3), $sformatf("rnd%0d", t));
         if ($urandom_range(0, 1) == 1)
            idle_chk($urandom_range(1, 3), $sformatf("rnd_idle%0d", t));
      end
      idle_chk(2, "final_idle");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
Serial bit-sequence transmitter. It is the driving end of the serial-detector interface: it produces the single-bit stream `x` that the sequence detector consumes. It loads a pattern of up to PAT_W bits and shifts it out MSB-first. Each bit is held for BIT_CYCLES clocks. The pattern can be repeated, with optional idle gaps between repetitions. It is used as a stimulus source and as an on-chip pattern injector.

Parameters:
PAT_W, 8, maximum pattern length in bits
LEN_W, 4, width of pat_len; must hold PAT_W
CNT_W, 8, width of repeat_n and gap
BIT_CYCLES, 3, clocks each bit is held on x; must be >= 1
IDLE_LEVEL, 1'b0, level driven on x when no pattern bit is active

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request; sampled only in IDLE
abort  input  1  synchronous abort of the current transfer
pattern  input  PAT_W  pattern; bit pat_len-1 is sent first, bit 0 last
pat_len  input  LEN_W  number of pattern bits, 1..PAT_W
repeat_n  input  CNT_W  extra repetitions; total sends = repeat_n+1
gap  input  CNT_W  idle bit-periods inserted between repetitions
x  output  1  serial data, registered
x_valid  output  1  high while x carries a pattern bit
busy  output  1  high from start acceptance until completion
done  output  1  one-clock pulse on normal completion

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, x=IDLE_LEVEL, x_valid=0, busy=0, done=0, all counters cleared. Outputs change immediately, without waiting for clk. Release is synchronous to the next rising edge.
- FSM states:
  - IDLE: x=IDLE_LEVEL, x_valid=0, busy=0.
  - SEND: x=current pattern bit, x_valid=1, busy=1.
  - GAP: x=IDLE_LEVEL, x_valid=0, busy=1.
- IDLE -> SEND: at a rising edge with start=1, abort=0, pat_len!=0.
  - pattern, effective length, repeat_n and gap are latched at that edge.
  - Bit pat_len-1 appears on x in the following cycle (one-clock latency).
  - pat_len > PAT_W is clamped to PAT_W. pat_len=0: start is ignored; stay in IDLE with no busy and no done.
- SEND: each bit is held exactly BIT_CYCLES clocks, then the next lower bit is driven.
- After the last bit (bit 0) period of a repetition:
  - More repetitions remain and gap>0: go to GAP for gap*BIT_CYCLES clocks, then SEND restarting at bit pat_len-1.
  - More repetitions remain and gap=0: restart at bit pat_len-1 immediately, with no idle cycle between repetitions.
  - Final repetition: go to IDLE. done=1 for exactly that one cycle; busy=0 and x_valid=0 in the same cycle.
- Back-to-back transfers: start is accepted in the done cycle (state is IDLE). The next transfer's first bit follows one cycle later.
- Sequence length: total clocks with x_valid=1 = (repeat_n+1)*pat_len*BIT_CYCLES.
- Internal counters are sized for the maximum values (repeat_n=2^CNT_W-1, gap=2^CNT_W-1) with no wrap-around.
- Inputs while busy: start is ignored. Changes on pattern, pat_len, repeat_n or gap have no effect on the transfer in progress.
- abort=1 at any rising edge while busy: next state IDLE, x=IDLE_LEVEL, x_valid=0, busy=0. No done pulse.
- abort and start both high in IDLE: abort wins and start is ignored.
- Reset asserted mid-transfer: the transfer is lost and no done pulse is produced. After release the block sits in IDLE until a new start.
- x, x_valid, busy and done are all registered outputs (glitch-free).

Test Plan:
- Single pattern, BIT_CYCLES=3: pattern=8'h0B, pat_len=4, repeat_n=0, gap=0; start high for edge E0.
  -> x=1 over E0–E3, 0 over E3–E6, 1 over E6–E9, 1 over E9–E12.
  -> x_valid=1 for 12 clocks; done=1 only in cycle E12–E13, where busy falls.
- Repeat with gap: pattern=8'h05, pat_len=3, repeat_n=1, gap=2.
  -> Bits 1,0,1 (9 clocks), then x=IDLE_LEVEL with x_valid=0 for 6 clocks, then 1,0,1 again.
  -> busy high for 24 clocks; exactly one done pulse.
- Back-to-back, gap=0: repeat_n=2, pat_len=2, pattern=8'h02.
  -> x = 1,0,1,0,1,0 with no idle cycles; x_valid continuous for 18 clocks.
  -> New start in the done cycle: x_valid rises one clock later.
- Abort and ignore cases:
  -> abort asserted at the 5th clock of a transfer: busy=0 and x_valid=0 after the next edge; no done pulse.
  -> start asserted while busy: no effect on the transfer.
  -> start with pat_len=0: busy stays 0.
- Async reset mid-SEND: reset=0 between clock edges -> x=0, x_valid=0, busy=0 immediately (before the next edge). After release the block stays in IDLE until start.
- Clamp and maximum: pat_len=15 with PAT_W=8 -> exactly 8 bits sent, pattern[7] first; repeat_n=255 -> 256 repetitions, a single done pulse.
